// File: rtl/cs_mac_accumulator_pkg.sv
// Shared types and defaults for the carry-save MAC accumulator.
// Holds the FSM state encoding and the default datapath widths.
package cs_mac_accumulator_pkg;

    localparam int unsigned ProdWDefault = 8;
    localparam int unsigned LenWDefault  = 4;
    localparam int unsigned AccWDefault  = 12;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAccum   = 2'b01,
        StResolve = 2'b10,
        StDone    = 2'b11
    } state_e;

endpackage

// File: rtl/cs_mac_accumulator_if.sv
// Control, product-stream and result-stream signals of the MAC accumulator.
// The slave modport is the accumulator; the master modport is its driver.
interface cs_mac_accumulator_if
    import cs_mac_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W = ProdWDefault,
    parameter int unsigned LEN_W  = LenWDefault,
    parameter int unsigned ACC_W  = AccWDefault
);

    logic              start_i;
    logic [LEN_W-1:0]  len_i;
    logic [PROD_W-1:0] prod_i;
    logic              prod_valid_i;
    logic              prod_ready_o;
    logic [ACC_W-1:0]  sum_o;
    logic              sum_valid_o;
    logic              sum_ready_i;
    logic              busy_o;

    modport slave (
        input  start_i,
        input  len_i,
        input  prod_i,
        input  prod_valid_i,
        output prod_ready_o,
        output sum_o,
        output sum_valid_o,
        input  sum_ready_i,
        output busy_o
    );

    modport master (
        output start_i,
        output len_i,
        output prod_i,
        output prod_valid_i,
        input  prod_ready_o,
        input  sum_o,
        input  sum_valid_o,
        output sum_ready_i,
        input  busy_o
    );

endinterface

// File: rtl/cs_mac_accumulator_csa_3to2.sv
// Bitwise full-adder row: compresses (a, b, c) into a sum vector and a carry vector
// already shifted left by one; the carry out of the top bit is dropped.
module cs_mac_accumulator_csa_3to2 #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] cy_o
);

    assign cy_o[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s_o[i] = a_i[i] ^ b_i[i] ^ c_i[i];
        if (i < W - 1) begin : g_cy
            assign cy_o[i+1] = (a_i[i] & b_i[i]) | (a_i[i] & c_i[i]) | (b_i[i] & c_i[i]);
        end
    end

endmodule

// File: rtl/cs_mac_accumulator.sv
// Dot-product accumulator: absorbs one product per cycle into a carry-save running sum,
// then resolves it with a single add and offers the result on a valid/ready handshake.
module cs_mac_accumulator
    import cs_mac_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W = ProdWDefault,
    parameter int unsigned LEN_W  = LenWDefault,
    parameter int unsigned ACC_W  = AccWDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    cs_mac_accumulator_if.slave   bus
);

    if (ACC_W < PROD_W + LEN_W) begin : g_bad_cfg
        $error("cs_mac_accumulator: ACC_W must be at least PROD_W + LEN_W");
    end

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   csa_s, csa_cy;

    assign prod_ext = {{(ACC_W - PROD_W){1'b0}}, bus.prod_i};

    cs_mac_accumulator_csa_3to2 #(
        .W (ACC_W)
    ) u_csa (
        .a_i  (s_q),
        .b_i  (c_q),
        .c_i  (prod_ext),
        .s_o  (csa_s),
        .cy_o (csa_cy)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        rem_d   = rem_q;
        sum_d   = sum_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    if (bus.len_i != '0) begin
                        rem_d   = bus.len_i;
                        s_d     = '0;
                        c_d     = '0;
                        state_d = StAccum;
                    end else begin
                        sum_d   = '0;
                        state_d = StDone;
                    end
                end
            end
            StAccum: begin
                if (bus.prod_valid_i) begin
                    s_d   = csa_s;
                    c_d   = csa_cy;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StResolve;
                    end
                end
            end
            StResolve: begin
                // Cannot overflow: ACC_W covers the largest possible dot product.
                sum_d   = s_q + c_q;
                state_d = StDone;
            end
            StDone: begin
                if (bus.sum_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            c_q     <= '0;
            rem_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            rem_q   <= rem_d;
            sum_q   <= sum_d;
        end
    end

    assign bus.prod_ready_o = (state_q == StAccum);
    assign bus.sum_valid_o  = (state_q == StDone);
    assign bus.busy_o       = (state_q != StIdle);
    assign bus.sum_o        = sum_q;

endmodule
